// File: rtl/cpu_defs.sv
// Shared encodings for the hardwired control sequencer: T-state numbering,
// instruction opcodes, one-hot ALU selects and the decoded instruction class.
package cpu_defs;

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_HALT = 4'd7
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [7:0] ALU_NONE = 8'h00;
  localparam logic [7:0] ALU_ADD  = 8'h01;
  localparam logic [7:0] ALU_AND  = 8'h02;
  localparam logic [7:0] ALU_OR   = 8'h04;
  localparam logic [7:0] ALU_SUB  = 8'h08;
  localparam logic [7:0] ALU_SHR  = 8'h10;
  localparam logic [7:0] ALU_SHL  = 8'h20;

  // Execution path selected in T3.
  typedef enum logic [2:0] {
    CLS_REG  = 3'd0,   // register-register ALU op
    CLS_IMM  = 3'd1,   // register-immediate ALU op
    CLS_NOP  = 3'd2,
    CLS_HALT = 3'd3,
    CLS_ILL  = 3'd4    // undefined opcode
  } op_class_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder: instruction class, ALU select and illegal flag.
module control_decode
  import cpu_defs::*;
(
  input  logic [4:0] opcode_i,
  output op_class_t  op_class_o,
  output logic [7:0] alu_ctrl_o,
  output logic       illegal_o
);

  // Map each opcode onto its execution path and ALU operation.
  always_comb begin
    op_class_o = CLS_ILL;
    alu_ctrl_o = ALU_NONE;
    illegal_o  = 1'b0;
    case (opcode_i)
      OP_ADD:  begin op_class_o = CLS_REG;  alu_ctrl_o = ALU_ADD; end
      OP_AND:  begin op_class_o = CLS_REG;  alu_ctrl_o = ALU_AND; end
      OP_OR:   begin op_class_o = CLS_REG;  alu_ctrl_o = ALU_OR;  end
      OP_SUB:  begin op_class_o = CLS_REG;  alu_ctrl_o = ALU_SUB; end
      OP_SHR:  begin op_class_o = CLS_REG;  alu_ctrl_o = ALU_SHR; end
      OP_SHL:  begin op_class_o = CLS_REG;  alu_ctrl_o = ALU_SHL; end
      OP_ADDI: begin op_class_o = CLS_IMM;  alu_ctrl_o = ALU_ADD; end
      OP_ANDI: begin op_class_o = CLS_IMM;  alu_ctrl_o = ALU_AND; end
      OP_ORI:  begin op_class_o = CLS_IMM;  alu_ctrl_o = ALU_OR;  end
      OP_NOP:  op_class_o = CLS_NOP;
      OP_HALT: op_class_o = CLS_HALT;
      default: begin op_class_o = CLS_ILL;  illegal_o  = 1'b1;    end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer driving the datapath control lines.
// One T-state per clock; outputs are decoded from the state (and the IR
// opcode in T3..T5). A bounded T1 stall aborts the fetch and restarts at T0.
module control_unit
  import cpu_defs::*;
#(
  parameter int IMEM_WAIT_MAX = 15
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Rout,
  output logic        Cout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Rin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        IncPC,
  output logic        read,
  output logic [7:0]  ALU_control,
  output logic        run,
  output logic        illegal_op,
  output logic [3:0]  state
);

  localparam int CNT_W = $clog2(IMEM_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMEM_WAIT_MAX - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;

  op_class_t  op_class;
  logic [7:0] alu_sel;
  logic       op_illegal;

  // Only the opcode field steers the sequencer; register fields go straight
  // to the datapath.
  logic unused_ir_fields;
  assign unused_ir_fields = ^IR[26:0];

  control_decode u_decode (
    .opcode_i   (IR[31:27]),
    .op_class_o (op_class),
    .alu_ctrl_o (alu_sel),
    .illegal_o  (op_illegal)
  );

  // State, stall counter and timeout pulse registers; clear forces RST at once.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q    <= ST_RST;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state selection; the stall counter only runs while T1 waits.
  always_comb begin
    state_d    = ST_T0;
    wait_cnt_d = '0;
    timeout_d  = 1'b0;
    case (state_q)
      ST_RST: state_d = ST_T0;
      ST_T0:  state_d = ST_T1;
      ST_T1: begin
        if (mem_ready) begin
          state_d = ST_T2;
        end else if (wait_cnt_q == CNT_LAST) begin
          state_d   = ST_T0;
          timeout_d = 1'b1;
        end else begin
          state_d    = ST_T1;
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_T2:  state_d = ST_T3;
      ST_T3: begin
        case (op_class)
          CLS_REG, CLS_IMM: state_d = ST_T4;
          CLS_HALT:         state_d = ST_HALT;
          default:          state_d = ST_T0;
        endcase
      end
      ST_T4: begin
        if (op_class == CLS_REG || op_class == CLS_IMM) state_d = ST_T5;
        else                                            state_d = ST_T0;
      end
      ST_T5:   state_d = ST_T0;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_T0;
    endcase
  end

  // Control-line decode; everything defaults low, run stays high outside HALT.
  always_comb begin
    PCout       = 1'b0;
    Zlowout     = 1'b0;
    MDRout      = 1'b0;
    Rout        = 1'b0;
    Cout        = 1'b0;
    MARin       = 1'b0;
    Zin         = 1'b0;
    PCin        = 1'b0;
    MDRin       = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    Rin         = 1'b0;
    Gra         = 1'b0;
    Grb         = 1'b0;
    Grc         = 1'b0;
    IncPC       = 1'b0;
    read        = 1'b0;
    ALU_control = ALU_NONE;
    run         = (state_q != ST_HALT);
    illegal_op  = timeout_q;
    case (state_q)
      ST_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      ST_T1: begin
        Zlowout = 1'b1;
        read    = 1'b1;
        MDRin   = 1'b1;
        // A zero stall count marks the entry cycle, the only one that loads PC.
        PCin    = (wait_cnt_q == '0);
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        if (op_class == CLS_REG || op_class == CLS_IMM) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end
        illegal_op = op_illegal;
      end
      ST_T4: begin
        if (op_class == CLS_REG) begin
          Grc         = 1'b1;
          Rout        = 1'b1;
          ALU_control = alu_sel;
          Zin         = 1'b1;
        end else if (op_class == CLS_IMM) begin
          Cout        = 1'b1;
          ALU_control = alu_sel;
          Zin         = 1'b1;
        end
      end
      ST_T5: begin
        if (op_class == CLS_REG || op_class == CLS_IMM) begin
          Zlowout = 1'b1;
          Gra     = 1'b1;
          Rin     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus a randomized
// instruction stream, each cycle compared against a per-instruction
// expected-cycle model built from the instruction semantics.
module tb_control_unit;

  logic        clock, clear, mem_ready;
  logic [31:0] IR;
  logic        PCout, Zlowout, MDRout, Rout, Cout, MARin, Zin, PCin, MDRin, IRin;
  logic        Yin, Rin, Gra, Grb, Grc, IncPC, read, run, illegal_op;
  logic [7:0]  ALU_control;
  logic [3:0]  state;

  int total_cnt = 0;
  int bad_cnt   = 0;
  bit pending_ill = 0;

  control_unit #(.IMEM_WAIT_MAX(15)) dut (
    .clock(clock), .clear(clear), .IR(IR), .mem_ready(mem_ready),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Rout(Rout), .Cout(Cout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .Rin(Rin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC),
    .read(read), .ALU_control(ALU_control), .run(run), .illegal_op(illegal_op),
    .state(state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Strobe bit positions inside the packed observation.
  localparam logic [18:0] M_PCOUT = 19'h1 << 18, M_ZLOW  = 19'h1 << 17,
                          M_MDROUT = 19'h1 << 16, M_ROUT = 19'h1 << 15,
                          M_COUT  = 19'h1 << 14, M_MARIN = 19'h1 << 13,
                          M_ZIN   = 19'h1 << 12, M_PCIN  = 19'h1 << 11,
                          M_MDRIN = 19'h1 << 10, M_IRIN  = 19'h1 << 9,
                          M_YIN   = 19'h1 << 8,  M_RIN   = 19'h1 << 7,
                          M_GRA   = 19'h1 << 6,  M_GRB   = 19'h1 << 5,
                          M_GRC   = 19'h1 << 4,  M_INCPC = 19'h1 << 3,
                          M_READ  = 19'h1 << 2,  M_RUN   = 19'h1 << 1,
                          M_ILL   = 19'h1;

  logic [30:0] obs;
  assign obs = {state, ALU_control, PCout, Zlowout, MDRout, Rout, Cout, MARin,
                Zin, PCin, MDRin, IRin, Yin, Rin, Gra, Grb, Grc, IncPC, read,
                run, illegal_op};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [30:0] mk(input logic [3:0] st, input logic [7:0] alu,
                                     input logic [18:0] m);
    return {st, alu, m};
  endfunction

  // Reference decode: 0 reg ALU, 1 imm ALU, 2 NOP, 3 HALT, 4 undefined.
  function automatic int ref_class(input logic [4:0] op, output logic [7:0] alu);
    alu = 8'h00;
    case (op)
      5'b00011: begin alu = 8'h01; return 0; end
      5'b00101: begin alu = 8'h02; return 0; end
      5'b00110: begin alu = 8'h04; return 0; end
      5'b00100: begin alu = 8'h08; return 0; end
      5'b00111: begin alu = 8'h10; return 0; end
      5'b01000: begin alu = 8'h20; return 0; end
      5'b01100: begin alu = 8'h01; return 1; end
      5'b01101: begin alu = 8'h02; return 1; end
      5'b01110: begin alu = 8'h04; return 1; end
      5'b11010: return 2;
      5'b11011: return 3;
      default:  return 4;
    endcase
  endfunction

  // One clock cycle: drive inputs, check the settled outputs, advance.
  task automatic step(input string tag, input logic [30:0] exp,
                      input logic [31:0] ir_v, input logic mr_v);
    IR = ir_v;
    mem_ready = mr_v;
    #2;
    check_eq(tag, {1'b0, obs}, {1'b0, exp});
    @(posedge clock);
    #1;
  endtask

  // Assert clear between edges, hold it across one edge, release; ends in T0.
  task automatic clear_seq(input string tag);
    clear = 1'b1;
    #1;
    check_eq({tag, "_async"}, {1'b0, obs}, {1'b0, mk(4'd0, 8'h00, M_RUN)});
    @(posedge clock);
    #1;
    check_eq({tag, "_hold"}, {1'b0, obs}, {1'b0, mk(4'd0, 8'h00, M_RUN)});
    clear = 1'b0;
    @(posedge clock);
    #1;
    pending_ill = 0;
  endtask

  // Run one instruction from T0 with the given number of T1 stall cycles.
  task automatic do_instr(input logic [31:0] ir, input int stalls, input bit abort_t4);
    logic [7:0]  alu;
    logic [31:0] garb;
    logic [18:0] m;
    int          cls, n_st;
    cls  = ref_class(ir[31:27], alu);
    garb = $urandom;
    $display("instr ir=%08h class=%0d stalls=%0d abort=%0d", ir, cls, stalls, abort_t4);
    m = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN | (pending_ill ? M_ILL : 19'h0);
    pending_ill = 0;
    step("T0", mk(4'd1, 8'h00, m), garb, 1'($urandom));
    n_st = (stalls > 15) ? 15 : stalls;
    for (int i = 0; i < n_st; i++)
      step("T1_stall", mk(4'd2, 8'h00, M_ZLOW | M_READ | M_MDRIN | M_RUN |
                                       ((i == 0) ? M_PCIN : 19'h0)), garb, 1'b0);
    if (stalls >= 15) begin
      pending_ill = 1;
      return;
    end
    step("T1_ready", mk(4'd2, 8'h00, M_ZLOW | M_READ | M_MDRIN | M_RUN |
                                     ((stalls == 0) ? M_PCIN : 19'h0)), garb, 1'b1);
    step("T2", mk(4'd3, 8'h00, M_MDROUT | M_IRIN | M_RUN), garb, 1'($urandom));
    case (cls)
      0, 1: begin
        step("T3_alu", mk(4'd4, 8'h00, M_GRB | M_ROUT | M_YIN | M_RUN), ir, 1'($urandom));
        m = (cls == 0) ? (M_GRC | M_ROUT | M_ZIN | M_RUN) : (M_COUT | M_ZIN | M_RUN);
        if (abort_t4) begin
          IR = ir;
          #2;
          check_eq("T4_pre_clear", {1'b0, obs}, {1'b0, mk(4'd5, alu, m)});
          clear_seq("clr_t4");
          return;
        end
        step("T4", mk(4'd5, alu, m), ir, 1'($urandom));
        step("T5", mk(4'd6, 8'h00, M_ZLOW | M_GRA | M_RIN | M_RUN), ir, 1'($urandom));
      end
      2: step("T3_nop", mk(4'd4, 8'h00, M_RUN), ir, 1'($urandom));
      3: begin
        step("T3_halt", mk(4'd4, 8'h00, M_RUN), ir, 1'($urandom));
        for (int k = 0; k < 3; k++)
          step("HALT", mk(4'd7, 8'h00, 19'h0), ir, 1'($urandom));
        clear_seq("clr_halt");
      end
      default: step("T3_ill", mk(4'd4, 8'h00, M_RUN | M_ILL), ir, 1'($urandom));
    endcase
  endtask

  logic [4:0] legal_ops [0:10] = '{5'b00011, 5'b00101, 5'b00110, 5'b00100,
                                   5'b00111, 5'b01000, 5'b01100, 5'b01101,
                                   5'b01110, 5'b11010, 5'b11010};

  initial begin
    logic [4:0]  op;
    logic [31:0] rnd;
    int          sel, st;
    clear = 1'b1;
    IR = 32'h0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("reset_state", {1'b0, obs}, {1'b0, mk(4'd0, 8'h00, M_RUN)});
    clear = 1'b0;
    @(posedge clock);
    #1;

    do_instr(32'h2A2B8000, 0, 0);   // AND, full T0..T5
    do_instr(32'h6000_0005, 0, 0);  // ADDI, Cout path
    do_instr(32'h1A2B8000, 3, 0);   // ADD with 3 stall cycles
    do_instr(32'h3000_0000, 20, 0); // stuck mem_ready -> timeout
    do_instr(32'h2000_0000, 14, 0); // ready on the last allowed T1 cycle
    do_instr(32'hD000_0000, 15, 0); // exactly at the timeout limit
    do_instr(32'hD000_0000, 0, 0);  // NOP (also checks pulse after timeout)
    do_instr(32'hF800_0000, 1, 0);  // undefined opcode
    do_instr(32'h2A2B8000, 0, 1);   // clear mid-T4

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 15);
      if (sel < 11) begin
        op = legal_ops[sel];
      end else begin
        op = 5'($urandom);
        if (op == 5'b11011) op = 5'b11111;
      end
      rnd = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 6)       st = $urandom_range(0, 3);
      else if (sel < 8)  st = 14;
      else if (sel == 8) st = 15;
      else               st = $urandom_range(16, 18);
      do_instr({op, rnd[26:0]}, st, 0);
    end

    do_instr(32'hD800_0000, 0, 0);  // HALT, then clear restores
    do_instr(32'h0C00_0000, 0, 0);  // undefined opcode after recovery

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer that drives the CPU datapath's bus-enable, register-load, memory and ALU select lines. It sits directly upstream of the datapath. It receives the instruction register contents and a memory-ready flag, and steps a fetch/decode/execute state machine one T-state per clock. It covers register ALU ops, immediate ALU ops, NOP and HALT. Register selection uses the select-and-encode fields (Gra/Grb/Grc), so the datapath decodes Ra/Rb/Rc from IR.

## Interface
Parameters:
- IMEM_WAIT_MAX, 15 — cycles T1 may stall on mem_ready before illegal_op fires and fetch restarts at T0.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- clear  in  1  asynchronous, active-high reset.
- IR  in  32  datapath instruction register. Fields: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15], C [18:0].
- mem_ready  in  1  memory data valid on Mdatain this cycle.
- PCout, Zlowout, MDRout, Rout, Cout  out  1 each  bus drive enables.
- MARin, Zin, PCin, MDRin, IRin, Yin, Rin  out  1 each  register load enables.
- Gra, Grb, Grc  out  1 each  register-field select for Rin/Rout.
- IncPC  out  1  ALU computes bus+1.
- read  out  1  memory read strobe.
- ALU_control  out  8  one-hot ALU op select.
- run  out  1  high while executing, low in HALT.
- illegal_op  out  1  one-cycle pulse: undefined opcode or fetch timeout.
- state  out  4  current state encoding (debug).

## Operation
- States:
  - RST=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, HALT=7.
  - The remaining encodings are unreachable and recover to T0 on the next edge.
- Moore decode: every output is a combinational function of state and the IR opcode only. Outputs not listed for a state are 0.
- RST: outputs 0, run=1. Next state T0.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, read, MDRin. Hold in T1 while mem_ready=0.
    - PCin pulses only on the entry cycle; read and MDRin are held.
    - Advance to T2 on mem_ready=1.
    - After IMEM_WAIT_MAX stalled cycles: pulse illegal_op, go to T0.
  - T2: MDRout, IRin.
- Opcodes, decoded in T3 from IR, which is loaded at the end of T2:
  - ADD 00011 → ALU_control 8'h01; AND 00101 → 8'h02; OR 00110 → 8'h04; SUB 00100 → 8'h08; SHR 00111 → 8'h10; SHL 01000 → 8'h20.
  - ADDI 01100 → 8'h01; ANDI 01101 → 8'h02; ORI 01110 → 8'h04.
  - NOP 11010; HALT 11011.
  - These encodings and the state encoding live in the shared package.
- Register ALU ops: T3 Grb, Rout, Yin; T4 Grc, Rout, ALU_control, Zin; T5 Zlowout, Gra, Rin; then T0.
- Immediate ops: T3 as above; T4 Cout, ALU_control, Zin; T5 as above; then T0.
- NOP: T3 asserts nothing, then T0.
- HALT: T3 → HALT. In HALT all strobes are 0, run=0; leave only via clear.
- Undefined opcode: illegal_op=1 during T3, no enables, then T0.
- ALU_control is 8'h00 in every state except T4 of an ALU op.

## Timing
- clear asserted: state=RST immediately, regardless of clock.
  - All outputs 0 except run=1.
  - Clear mid-instruction aborts it; no partial Rin is issued after clear rises.
- First rising edge after clear falls: RST→T0.
- Instruction latency, with mem_ready high in T1:
  - ALU op: 6 cycles (T0–T5).
  - NOP / illegal: 4 cycles.
  - HALT: reaches HALT after 4 edges.
- Each T1 stall cycle adds one cycle.
- The timeout counter resets on T1 entry; it counts cycles with mem_ready=0.
- mem_ready on the same edge as the timeout limit: mem_ready wins, go to T2.
- illegal_op is a Moore output of T3, or a registered pulse for the T1 timeout; never 2 consecutive cycles.
- Outputs settle within the cycle; the datapath samples them on the next rising edge.

## Structure
- Package cpu_defs: opcode localparams, ALU_control one-hot constants, state encodings.
- Sub-module control_decode: combinational opcode → {class, ALU_control, illegal}.
- control_unit holds the state register, timeout counter and output decode.

## Test plan
- clear high at reset, release, mem_ready=1, IR=32'h2A2B8000 (AND) at end of T2:
  - states T0..T5 in order;
  - T4 shows ALU_control=8'h02, Grc, Rout, Zin;
  - T5 shows Zlowout, Gra, Rin;
  - returns to T0.
- ADDI IR=32'h6000_0005: T4 asserts Cout and ALU_control=8'h01, not Rout.
- mem_ready low for 3 cycles in T1:
  - T1 held 4 cycles with read and MDRin held;
  - PCin high only in the first of those cycles;
  - then T2.
- mem_ready stuck low: illegal_op pulses after 15 stall cycles, state returns to T0.
- HALT IR=32'hD800_0000: state=HALT, run=0 thereafter; clear pulse restores RST, then T0.
- clear asserted asynchronously mid-T4: outputs drop to 0 without waiting for a clock edge; state=RST.
